enc: RTL

ENC -- requirements
Module: enc

---
 rtl/enc.sv | 129 ++++++++++++
 1 files changed

// File: rtl/enc.sv
// RV32I instruction encoder with a 2-entry output FIFO.
// Optional immediate range checking is compiled in with ENC_RANGE_CHECK_EN.
module enc #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [4:0]       in_sopcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic [6:0]  opcode;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        range_err;

    logic [32:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  occ;
    logic        push;
    logic        pop;

    assign opcode = {in_sopcode, 2'b11};

    always_comb begin
        enc_instr = NOP_WORD;
        enc_err   = 1'b0;
        case (in_fmt)
            FMT_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, opcode};
            FMT_I: enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, opcode};
            FMT_S: enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], opcode};
            FMT_B: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], opcode};
            FMT_U: enc_instr = {in_imm[31:12], in_rd, opcode};
            FMT_J: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, opcode};
            default: begin
                enc_instr = NOP_WORD;
                enc_err   = 1'b1;
            end
        endcase
        enc_err = enc_err | range_err;
    end

`ifdef ENC_RANGE_CHECK_EN
    // Words that do not fit their field are still packed (truncated) but flagged.
    logic signed [31:0] simm;
    assign simm = $signed(in_imm);

    always_comb begin
        range_err = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: range_err = (simm < -32'sd2048) || (simm > 32'sd2047);
            FMT_B:        range_err = (simm < -32'sd4096) || (simm > 32'sd4094) || in_imm[0];
            FMT_J:        range_err = (simm < -32'sd1048576) || (simm > 32'sd1048574) || in_imm[0];
            FMT_U:        range_err = (in_imm[11:0] != 12'd0);
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    // Ready depends only on registered occupancy (and reset), never on out_ready.
    assign in_ready  = !rst && (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign out_instr = out_valid ? mem[rd_ptr][31:0] : 32'd0;
    assign out_err   = out_valid ? mem[rd_ptr][32]   : 1'b0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {enc_err, enc_instr};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (pop) begin
            out_cnt <= out_cnt + 1'b1;
        end
    end

endmodule
